game_sequencer: RTL

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_sequencer.sv | 104 ++++++++++
 1 files changed

// File: rtl/game_sequencer.sv
// game_sequencer: game flow control: monitor-sync wait, serve, play, miss pause, game over/won, restart on button.
module game_sequencer #(
  parameter int SYNC_CYCLES  = 100000000,
  parameter int SERVE_FRAMES = 60,
  parameter int MISS_FRAMES  = 90,
  parameter int LIVES        = 3
) (
  input  logic       pxl_clk,
  input  logic       reset_n,
  input  logic       vsync,
  input  logic       lose,
  input  logic       win,
  input  logic       btn,
  output logic       start,
  output logic       ball_reset,
  output logic       board_reset,
  output logic [1:0] lives_left,
  output logic       game_over,
  output logic       game_won,
  output logic [2:0] state
);
  typedef enum logic [2:0] {
    SYNC_WAIT = 3'd0,
    SERVE     = 3'd1,
    PLAY      = 3'd2,
    MISS      = 3'd3,
    OVER      = 3'd4,
    WON       = 3'd5
  } state_t;

  state_t      st, st_n;
  logic        vsync_q, btn_q, tick, rise, brd_n;
  logic [26:0] cyc, cyc_n;
  logic [7:0]  frm, frm_n, frm_inc;
  logic [1:0]  lives_n;

  assign state = st;

  always_comb begin
    tick    = vsync_q & ~vsync;
    rise    = btn & ~btn_q;
    frm_inc = (frm == 8'hff) ? frm : frm + 8'd1;
    st_n    = st;
    cyc_n   = cyc;
    frm_n   = frm;
    lives_n = lives_left;
    brd_n   = 1'b0;
    case (st)
      SYNC_WAIT: begin
        cyc_n = (cyc == 27'(SYNC_CYCLES - 1)) ? '0 : cyc + 27'd1;
        st_n  = (cyc == 27'(SYNC_CYCLES - 1)) ? SERVE : SYNC_WAIT;
      end
      SERVE: if (tick) begin
        frm_n = (frm == 8'(SERVE_FRAMES - 1)) ? '0 : frm_inc;
        st_n  = (frm == 8'(SERVE_FRAMES - 1)) ? PLAY : SERVE;
      end
      PLAY: if (win) st_n = WON;
      else if (lose) begin
        lives_n = lives_left - 2'd1;
        st_n    = (lives_left == 2'd1) ? OVER : MISS;
      end
      MISS: if (tick) begin
        frm_n = (frm == 8'(MISS_FRAMES - 1)) ? '0 : frm_inc;
        st_n  = (frm == 8'(MISS_FRAMES - 1)) ? SERVE : MISS;
      end
      OVER, WON: if (rise) begin
        st_n    = SERVE;
        lives_n = 2'(LIVES);
        frm_n   = '0;
        brd_n   = 1'b1;
      end
      default: st_n = SYNC_WAIT;
    endcase
  end

  // outputs are registered from the next state so they line up with state
  always_ff @(posedge pxl_clk) begin
    if (!reset_n) begin
      st          <= SYNC_WAIT;
      vsync_q     <= 1'b1;
      btn_q       <= 1'b1;
      cyc         <= '0;
      frm         <= '0;
      lives_left  <= 2'(LIVES);
      start       <= 1'b0;
      ball_reset  <= 1'b1;
      board_reset <= 1'b0;
      game_over   <= 1'b0;
      game_won    <= 1'b0;
    end else begin
      st          <= st_n;
      vsync_q     <= vsync;
      btn_q       <= btn;
      cyc         <= cyc_n;
      frm         <= frm_n;
      lives_left  <= lives_n;
      start       <= (st_n == PLAY);
      ball_reset  <= (st_n != PLAY);
      board_reset <= brd_n;
      game_over   <= (st_n == OVER);
      game_won    <= (st_n == WON);
    end
  end
endmodule
